// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and extends the immediate of a
// RISC-V instruction to XLEN bits and queues it, with a sideband tag, in a
// 2-entry valid/ready buffer that supports synchronous flush.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] OP_I    = 3'b000;
  localparam logic [2:0] OP_U    = 3'b001;
  localparam logic [2:0] OP_S    = 3'b010;
  localparam logic [2:0] OP_B    = 3'b011;
  localparam logic [2:0] OP_J    = 3'b100;
  localparam logic [2:0] OP_Z    = 3'b101;
  localparam logic [2:0] OP_SH   = 3'b110;

  logic signed [31:0] sx_i;
  logic signed [31:0] sx_u;
  logic signed [31:0] sx_s;
  logic signed [31:0] sx_b;
  logic signed [31:0] sx_j;
  logic [XLEN-1:0]    imm_c;

  logic [XLEN-1:0]    mem_imm [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  // Opcode bits play no part in any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // Immediate extraction; signed 32-bit forms widen to XLEN by sign extension.
  always_comb begin
    sx_i  = {{20{inst[31]}}, inst[31:20]};
    sx_u  = {inst[31:12], 12'b0};
    sx_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    sx_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    sx_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_c = '0;
    case (ext_op)
      OP_I:    imm_c = XLEN'(sx_i);
      OP_U:    imm_c = XLEN'(sx_u);
      OP_S:    imm_c = XLEN'(sx_s);
      OP_B:    imm_c = XLEN'(sx_b);
      OP_J:    imm_c = XLEN'(sx_j);
      OP_Z:    imm_c = XLEN'(inst[19:15]);
      OP_SH:   imm_c = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      default: imm_c = '0;
    endcase
  end

  assign in_ready  = (count != CNT_W'(2));
  assign out_valid = (count != CNT_W'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Buffer storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= imm_c;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head entry is presented only while valid; otherwise outputs are zero.
  assign imm     = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Decode-stage immediate generator for the pipelined core. Extracts and sign- or zero-extends the immediate of a 32-bit RISC-V instruction to XLEN bits. Carries a sideband tag (normally the PC) alongside it. Sits between fetch/decode and the ID/EX boundary behind a 2-entry valid/ready buffer with synchronous flush. Extends the single-cycle combinational extractor with XLEN generalisation, CSR-uimm and shamt modes, and pipelined handshaking.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- TAG_W, 32, width of the sideband tag carried with each entry
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; empties the buffer
- in_valid  in  1  upstream entry valid
- in_ready  out  1  buffer can accept an entry
- inst  in  32  raw instruction
- ext_op  in  3  immediate format select
- in_tag  in  TAG_W  sideband (PC)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- imm  out  XLEN  extended immediate of the head entry
- out_tag  out  TAG_W  tag of the head entry

## Operation
- ext_op encodings: 000 I, 001 U, 010 S, 011 B, 100 J, 101 Z, 110 SH, 111 none.
- Sign extension is always from inst[31], out to XLEN bits.
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
  - U: sext({inst[31:12], 12'b0}). With XLEN=64, bits 63:32 replicate inst[31].
- Z (CSR immediate): zero-extend inst[19:15].
- SH (shift amount):
  - XLEN=32: zero-extend inst[24:20].
  - XLEN=64: zero-extend inst[25:20].
- none (111): imm = 0.
- Extraction is combinational on the input side. The result is written into the buffer together with in_tag.
- Buffer: 2-entry FIFO with occupancy count 0..2, read and write pointers, and in-order delivery.
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (count != 2). It depends on registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- When out_valid=0, imm and out_tag are driven 0.
- Simultaneous push and pop at count=1: count stays 1, the pointers advance, and the new entry follows the popped one.
- At count=2, push cannot occur. A pop makes in_ready=1 on the following cycle.
- flush has priority over push and pop. On the next edge: count=0, pointers=0, and any same-cycle push is dropped. A same-cycle pop is still considered taken by downstream.

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, stored entries=0.
  - While rst_n is low: out_valid=0, imm=0, out_tag=0, in_ready=1.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is presented at the output (out_valid=1) in the cycle after edge N, provided it is at the head.
- Throughput: 1 entry/cycle when out_ready is held high.
- Output data is stable while out_valid=1 and out_ready=0.
- Upstream must hold inst, ext_op and in_tag stable while in_valid=1 and in_ready=0.

## Test plan
- Formats, XLEN=32: each input is pushed with out_ready=1, and each result must appear with out_valid=1 one cycle after the push.
  - inst=0xFFF00093, ext_op=000 -> imm=0xFFFFFFFF
  - inst=0xFE000EE3, ext_op=011 -> imm=0xFFFFFFFC
  - inst=0x008000EF, ext_op=100 -> imm=0x00000008
  - inst=0x000FD073, ext_op=101 -> imm=0x0000001F
- XLEN=64:
  - inst=0x800000B7, ext_op=001 -> imm=0xFFFFFFFF80000000
  - inst=0x03F0D093, ext_op=110 -> imm=0x3F
  - same SH inst with XLEN=32 -> imm=0x1F
- Backpressure: out_ready=0 while pushing tags 1, 2, 3.
  - Tags 1 and 2 are accepted, then in_ready=0 and tag 3 is held.
  - Raising out_ready delivers tags 1, 2, 3 in order on consecutive cycles.
- Concurrency at count=1: push and pop every cycle for 10 cycles. count stays 1 and no entry is lost or duplicated.
- Flush: count=2 plus a concurrent valid push with flush=1. Next cycle out_valid=0, in_ready=1, and the flushed and pushed entries never appear.
- Async reset: rst_n pulled low between edges with count=1. out_valid, imm and out_tag go 0 before the next edge. After release, the first push yields out_valid one cycle later.
